disp_history_feeder: RTL and testbench

Upstream feeder for the eight-digit seven-segment scanner. It captures 32-bit words from the datapath over a valid/ready handshake into a circular history buffer. It drives the scanner's 32-bit `data` input with either the newest word (live mode) or an older entry chosen by three push-buttons (browse mode). Button inputs are synchronised and optionally debounced inside the block.

---
 rtl/disp_history_feeder.sv | 150 +++++++++++++++
 tb/tb_disp_history_feeder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/disp_history_feeder.sv
// History buffer feeding the 8-digit scanner; push-buttons browse older words (optional debounce: DISP_BTN_DEBOUNCE_EN).
// Latency: an accepted word reaches data one edge after capture; button pulse 2 (+DEB_CYCLES) cycles after a stable press.
// Backpressure: in_ready drops only while browsing a full buffer, so the viewed entry can never be overwritten.
module disp_history_feeder #(
    parameter int DEPTH      = 8,
    parameter int DEB_CYCLES = 32768
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    input  logic        btn_prev,
    input  logic        btn_next,
    input  logic        btn_live,
    output logic [31:0] data,
    output logic [3:0]  view_idx,
    output logic        live
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {MODE_LIVE, MODE_BROWSE} mode_t;

    if ((DEB_CYCLES < 2) || (DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_param
        $error("disp_history_feeder: illegal DEPTH or DEB_CYCLES");
    end

    // bit 2 = live, bit 1 = prev, bit 0 = next
    logic [2:0] sync1_q, sync2_q;
    logic [2:0] lvl;
    logic [2:0] lvl_dly_q;
    logic [2:0] pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            lvl_dly_q <= '0;
        end else begin
            sync1_q   <= {btn_live, btn_prev, btn_next};
            sync2_q   <= sync1_q;
            lvl_dly_q <= lvl;
        end
    end

`ifdef DISP_BTN_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] cnt_q [3];
    logic [2:0]    lvl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == lvl_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    cnt_q[i] <= '0;
                    lvl_q[i] <= sync2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign lvl = lvl_q;
`else
    assign lvl = sync2_q;
`endif

    assign pulse = lvl & ~lvl_dly_q;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic [AW-1:0] offset_q, offset_d;
    mode_t         mode_q, mode_d;
    logic [31:0]   data_q, data_d;
    logic [AW-1:0] rd_idx;
    logic          accept;

    assign in_ready = (mode_q == MODE_LIVE) || (fill_q != FULL);
    assign accept   = in_valid && in_ready;

    // Accept adjustment first, then at most one button action on the adjusted state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        offset_d = offset_q;
        mode_d   = mode_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (fill_q != FULL) fill_d = fill_q + 1'b1;
            if (mode_q == MODE_BROWSE) offset_d = offset_q + 1'b1;
        end
        if (pulse[2]) begin
            offset_d = '0;
            mode_d   = MODE_LIVE;
        end else if (pulse[1]) begin
            if ((fill_d >= (AW+1)'(2)) && ({1'b0, offset_d} < (fill_d - 1'b1))) begin
                offset_d = offset_d + 1'b1;
                mode_d   = MODE_BROWSE;
            end
        end else if (pulse[0]) begin
            if (offset_d != '0) begin
                offset_d = offset_d - 1'b1;
                if (offset_d == '0) mode_d = MODE_LIVE;
            end
        end
    end

    assign rd_idx = wr_ptr_q - AW'(1) - offset_q;

    always_comb begin
        data_d = '0;
        if (fill_q != '0) data_d = mem_q[rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
            offset_q <= '0;
            mode_q   <= MODE_LIVE;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            offset_q <= offset_d;
            mode_q   <= mode_d;
            data_q   <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= in_data;
    end

    assign data     = data_q;
    assign view_idx = 4'(offset_q);
    assign live     = (mode_q == MODE_LIVE);

endmodule

// File: tb/tb_disp_history_feeder.sv
// Directed checks of disp_history_feeder with DEPTH=8, DEB_CYCLES=4.
module tb_disp_history_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        btn_prev, btn_next, btn_live;
    logic [31:0] data;
    logic [3:0]  view_idx;
    logic        live;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] B_NEXT = 3'b001;
    localparam logic [2:0] B_PREV = 3'b010;
    localparam logic [2:0] B_LIVE = 3'b100;

    disp_history_feeder #(.DEPTH(8), .DEB_CYCLES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .btn_prev (btn_prev),
        .btn_next (btn_next),
        .btn_live (btn_live),
        .data     (data),
        .view_idx (view_idx),
        .live     (live)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        btn_prev = 1'b0;
        btn_next = 1'b0;
        btn_live = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Offers one word; returns on the falling edge right after the accepting edge.
    task automatic push(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
        chk("push_rdy", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic press(input logic [2:0] m);
        {btn_live, btn_prev, btn_next} = m;
        repeat (12) @(negedge clk);
        {btn_live, btn_prev, btn_next} = 3'b000;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        logic accepted;
        logic [31:0] exp_v;

        do_reset();
        // reset state and write-to-display latency
        chk("rst_data",  data, 32'h0);
        chk("rst_live",  {31'b0, live}, 32'd1);
        chk("rst_view",  {28'b0, view_idx}, 32'd0);
        chk("rst_rdy",   {31'b0, in_ready}, 32'd1);
        push(32'h1111_1111);
        chk("lat_before", data, 32'h0);
        @(negedge clk);
        chk("lat_after", data, 32'h1111_1111);

        // wrap-around history and browsing
        do_reset();
        for (int i = 1; i <= 10; i++) push(32'(i));
        @(negedge clk);
        chk("wrap_live_data", data, 32'hA);
        repeat (3) press(B_PREV);
        chk("prev3_view", {28'b0, view_idx}, 32'd3);
        chk("prev3_data", data, 32'h7);
        chk("prev3_live", {31'b0, live}, 32'd0);
        press(B_LIVE);
        chk("live_data", data, 32'hA);
        chk("live_view", {28'b0, view_idx}, 32'd0);
        chk("live_live", {31'b0, live}, 32'd1);

        // prev saturates at fill-1, next returns to live
        do_reset();
        push(32'hA); push(32'hB); push(32'hC);
        repeat (5) press(B_PREV);
        chk("sat_view", {28'b0, view_idx}, 32'd2);
        chk("sat_data", data, 32'hA);
        press(B_NEXT);
        chk("next1_view", {28'b0, view_idx}, 32'd1);
        chk("next1_data", data, 32'hB);
        press(B_NEXT);
        chk("next2_live", {31'b0, live}, 32'd1);
        chk("next2_data", data, 32'hC);
        press(B_NEXT);
        chk("next_at0_view", {28'b0, view_idx}, 32'd0);

        // browse while pushing, then stall on full
        do_reset();
        for (int i = 1; i <= 5; i++) push(32'(i));
        press(B_PREV);
        chk("b_view1", {28'b0, view_idx}, 32'd1);
        chk("b_data1", data, 32'h4);
        push(32'hD);
        @(negedge clk);
        chk("b_view2", {28'b0, view_idx}, 32'd2);
        chk("b_data2", data, 32'h4);
        push(32'hE); push(32'hF);
        @(negedge clk);
        chk("full_view", {28'b0, view_idx}, 32'd4);
        in_valid = 1'b1;
        in_data  = 32'h10;
        repeat (3) @(negedge clk);
        chk("stall_rdy",  {31'b0, in_ready}, 32'd0);
        chk("stall_data", data, 32'h4);
        btn_live = 1'b1;
        accepted = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                @(negedge clk);
                in_valid = 1'b0;
                break;
            end
        end
        in_valid = 1'b0;
        chk("stall_released", {31'b0, accepted}, 32'd1);
        btn_live = 1'b0;
        repeat (12) @(negedge clk);
        chk("rel_rdy",  {31'b0, in_ready}, 32'd1);
        chk("rel_view", {28'b0, view_idx}, 32'd0);
        chk("rel_data", data, 32'h10);
        press(B_PREV);
        chk("rel_prev_data", data, 32'hF);

        // short glitch, then a long hold
        do_reset();
        push(32'h1); push(32'h2); push(32'h3);
        btn_prev = 1'b1;
        repeat (3) @(negedge clk);
        btn_prev = 1'b0;
        repeat (12) @(negedge clk);
`ifdef DISP_BTN_DEBOUNCE_EN
        exp_v = 32'd0;
`else
        exp_v = 32'd1;
`endif
        chk("glitch_view", {28'b0, view_idx}, exp_v);
        btn_prev = 1'b1;
        repeat (20) @(negedge clk);
        btn_prev = 1'b0;
        repeat (12) @(negedge clk);
        chk("hold_view", {28'b0, view_idx}, exp_v + 32'd1);

        // live beats prev; reset mid-browse
        do_reset();
        for (int i = 1; i <= 4; i++) push(32'h20 + 32'(i));
        repeat (2) press(B_PREV);
        chk("pri_pre_view", {28'b0, view_idx}, 32'd2);
        chk("pri_pre_data", data, 32'h22);
        press(B_PREV | B_LIVE);
        chk("pri_view", {28'b0, view_idx}, 32'd0);
        chk("pri_live", {31'b0, live}, 32'd1);
        press(B_PREV);
        chk("mid_view", {28'b0, view_idx}, 32'd1);
        btn_next = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_data", data, 32'h0);
        chk("arst_view", {28'b0, view_idx}, 32'd0);
        chk("arst_live", {31'b0, live}, 32'd1);
        chk("arst_rdy",  {31'b0, in_ready}, 32'd1);
        btn_next = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_rst_data", data, 32'h0);
        chk("post_rst_view", {28'b0, view_idx}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
